// File: rtl/ad9866_spi_responder.sv
// ad9866_spi_responder: AD9866 3-wire SPI target decoding 16-bit frames into a 32x8 register file.
// Optional read-back on sdo is compiled in when AD9866_SPI_READBACK_EN is defined.
module ad9866_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       IF_clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       sen_n,
    input  logic       sdio,
    output logic       sdo,
    output logic       sdo_oe,
    output logic       wr_strobe,
    output logic [4:0] wr_addr,
    output logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] err_count,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sclk_q, sen_q, sdio_q, fill;
    logic                   sclk_d, sen_d, armed;
    logic                   sclk_s, sen_s, sdio_s;
    logic                   sclk_rise, sclk_fall, sen_rise, sen_fall;
    logic [4:0]             cnt, cnt_n;
    logic [14:0]            frame, frame_n;
    logic [15:0]            word;
    logic [7:0]             tx, tx_n;
    logic                   oe_n, strobe_n, err;
    logic [4:0]             addr_n;
    logic [7:0]             data_n;
    logic [7:0]             regs [32];

    assign sclk_s    = sclk_q[SYNC_STAGES-1];
    assign sen_s     = sen_q[SYNC_STAGES-1];
    assign sdio_s    = sdio_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign sen_rise  = sen_s & ~sen_d;
    assign sen_fall  = armed & sen_d & ~sen_s;
    assign word      = {frame, sdio_s};
    assign sdo       = tx[7];
    assign busy      = ~sen_s;
    assign rd_data   = regs[rd_addr];

    // Input synchronizers; armed only once a genuine high sen_n has been sampled after reset
    always_ff @(posedge IF_clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_q <= '0;
            sen_q  <= '1;
            sdio_q <= '0;
            fill   <= '0;
            sclk_d <= 1'b0;
            sen_d  <= 1'b1;
            armed  <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk};
            sen_q  <= {sen_q[SYNC_STAGES-2:0], sen_n};
            sdio_q <= {sdio_q[SYNC_STAGES-2:0], sdio};
            fill   <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_d <= sclk_s;
            sen_d  <= sen_s;
            armed  <= armed | (fill[SYNC_STAGES-1] & sen_s);
        end
    end

    // Frame FSM state and registered outputs
    always_ff @(posedge IF_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            frame     <= '0;
            tx        <= '0;
            sdo_oe    <= 1'b0;
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            err_count <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            frame     <= frame_n;
            tx        <= tx_n;
            sdo_oe    <= oe_n;
            wr_strobe <= strobe_n;
            wr_addr   <= addr_n;
            wr_data   <= data_n;
            if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

    // Next-state: bit counting, frame decode, read-back shifting and error detection
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        frame_n  = frame;
        tx_n     = tx;
        oe_n     = sdo_oe;
        strobe_n = 1'b0;
        addr_n   = wr_addr;
        data_n   = wr_data;
        err      = 1'b0;
        if (sen_rise) begin
            state_n = IDLE;
            cnt_n   = '0;
            tx_n    = '0;
            oe_n    = 1'b0;
            err     = cnt != 5'd0 && cnt != 5'd16;
        end else if (sen_fall) begin
            state_n = SHIFT;
            cnt_n   = '0;
            frame_n = '0;
        end else if (state == SHIFT && sclk_rise) begin
            frame_n = word[14:0];
            cnt_n   = cnt + 5'd1;
`ifdef AD9866_SPI_READBACK_EN
            if (cnt == 5'd7 && word[7] && word[6:5] == 2'b00) begin
                tx_n = regs[word[4:0]];
                oe_n = 1'b1;
            end
`endif
            if (cnt == 5'd15) begin
                state_n = DONE;
                if (word[14:13] != 2'b00) err = 1'b1;
                else if (!word[15]) begin
                    strobe_n = 1'b1;
                    addr_n   = word[12:8];
                    data_n   = word[7:0];
                end
            end
        end else if (state == SHIFT && sclk_fall && sdo_oe && cnt >= 5'd9) begin
            tx_n = {tx[6:0], 1'b0};
        end
    end

    // Register file commits the write one cycle after the strobe
    always_ff @(posedge IF_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (wr_strobe) begin
            regs[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_ad9866_spi_responder.sv
// tb_ad9866_spi_responder: randomized frames against a register-file/error-count reference model.
module tb_ad9866_spi_responder;
    logic       IF_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       sen_n = 1'b1;
    logic       sdio = 1'b0;
    logic [4:0] rd_addr = '0;
    logic       sdo, sdo_oe, wr_strobe, busy;
    logic [4:0] wr_addr;
    logic [7:0] wr_data, rd_data, err_count;

`ifdef AD9866_SPI_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    ad9866_spi_responder #(.SYNC_STAGES(2)) dut (
        .IF_clk(IF_clk), .rst_n(rst_n), .sclk(sclk), .sen_n(sen_n), .sdio(sdio),
        .sdo(sdo), .sdo_oe(sdo_oe), .wr_strobe(wr_strobe), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
        .err_count(err_count), .busy(busy)
    );

    always #5 IF_clk = ~IF_clk;

    int         n_checks = 0;
    int         n_fail = 0;
    int         strobes = 0;
    logic [4:0] s_addr;
    logic [7:0] s_data;
    logic [7:0] mem [32];
    int         exp_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Record every write strobe seen by the fabric
    always @(negedge IF_clk) begin
        if (wr_strobe === 1'b1) begin
            strobes++;
            s_addr = wr_addr;
            s_data = wr_data;
        end
    end

    // Shift nbits of w (extra bits random); collect sdo on rising edges 9-16
    task automatic shift_bits(input logic [15:0] w, input int nbits,
                              output logic [7:0] rx, output int oe_hi);
        rx = '0;
        oe_hi = 0;
        for (int i = 0; i < nbits; i++) begin
            sdio = (i < 16) ? w[15-i] : 1'($urandom_range(0, 1));
            repeat (8) @(negedge IF_clk);
            if (i >= 8 && i < 16) begin
                rx = {rx[6:0], sdo};
                if (sdo_oe) oe_hi++;
            end
            sclk = 1'b1;
            repeat (8) @(negedge IF_clk);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [15:0] w, input int nbits);
        logic [7:0] rx;
        int         oe_hi, s0, n;
        logic       oe_end, rd_ok, wr_ok;
        logic [4:0] a;
        s0 = strobes;
        a = w[12:8];
        sen_n = 1'b0;
        repeat (8) @(negedge IF_clk);
        shift_bits(w, nbits, rx, oe_hi);
        repeat (8) @(negedge IF_clk);
        oe_end = sdo_oe;
        sen_n = 1'b1;
        sdio = 1'b0;
        repeat (12) @(negedge IF_clk);
        rd_ok = RB && w[15] && w[14:13] == 2'b00;
        wr_ok = nbits >= 16 && !w[15] && w[14:13] == 2'b00;
        n = (nbits >= 16) ? 8 : (nbits > 8 ? nbits - 8 : 0);
        if (nbits >= 8) check("oe_before_sen_high", oe_end, rd_ok);
        if (n > 0) begin
            check("rd_oe_bits", oe_hi, rd_ok ? n : 0);
            check("rd_sdo_bits", rx, rd_ok ? 32'(mem[a] >> (8 - n)) : 0);
        end
        if ((nbits > 0 && nbits < 16) || (nbits >= 16 && w[14:13] != 2'b00))
            exp_err = (exp_err == 255) ? 255 : exp_err + 1;
        if (wr_ok) mem[a] = w[7:0];
        check("strobe_count", strobes - s0, wr_ok);
        if (wr_ok) check("wr_addr_data", {s_addr, s_data}, {a, w[7:0]});
        check("err_count", err_count, exp_err);
        check("idle_sdo", {sdo_oe, sdo}, 0);
        check("idle_busy", busy, 0);
        rd_addr = a;
        @(negedge IF_clk);
        check("rd_data", rd_data, mem[a]);
    endtask

    task automatic check_reset_vals();
        check("rst_sdo", sdo, 0);
        check("rst_sdo_oe", sdo_oe, 0);
        check("rst_wr_strobe", wr_strobe, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_err_count", err_count, 0);
        check("rst_busy", busy, 0);
        for (int i = 0; i < 32; i += 5) begin
            rd_addr = 5'(i);
            #1 check("rst_rd_data", rd_data, 0);
        end
    endtask

    initial begin
        logic [7:0]  rx;
        int          oe_hi;
        logic [15:0] w;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        repeat (5) @(negedge IF_clk);
        check_reset_vals();
        rst_n = 1'b1;
        repeat (10) @(negedge IF_clk);

        frame(16'h0A5C, 16);
        frame(16'h8A00, 16);
        frame(16'h0133, 10);
        frame(16'h0133, 16);
        frame(16'h6A11, 16);
        frame(16'h0000, 0);

        // Reset mid-frame after bit 12
        sen_n = 1'b0;
        repeat (8) @(negedge IF_clk);
        shift_bits(16'h0A77, 12, rx, oe_hi);
        rst_n = 1'b0;
        repeat (3) @(negedge IF_clk);
        for (int i = 0; i < 32; i++) mem[i] = '0;
        exp_err = 0;
        check_reset_vals();
        rst_n = 1'b1;
        repeat (10) @(negedge IF_clk);
        check("busy_after_reset", busy, 1);
        sen_n = 1'b1;
        repeat (12) @(negedge IF_clk);
        check("err_after_reset", err_count, 0);
        frame(16'h1FFF, 16);
        frame(16'h9F00, 16);

        // Random frames: mostly complete, some aborted or overlong, some with reserved bits
        for (int k = 0; k < 40; k++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) != 0) w[14:13] = 2'b00;
            frame(w, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 18)) : 16);
        end

        // Saturation of the error counter
        for (int k = 0; k < 300; k++) frame(16'($urandom), int'($urandom_range(1, 3)));
        check("err_saturated", err_count, 8'hFF);
        frame(16'h0A5C, 16);
        frame(16'h8A00, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ad9866_spi_responder.md
# ad9866_spi_responder

Target-side (responder) end of the AD9866 3-wire SPI control link. The block decodes serial frames on sclk/sen_n/sdio into a 32×8 register file, issues a one-cycle write strobe to fabric, and serves read-back on sdo. It sits on an expansion/emulation board, or in the system bench, opposite the core's AD9866 SPI initiator. All SPI inputs are oversampled in the IF_clk domain.

## Interface

Parameters:
- SYNC_STAGES, 2: synchronizer depth on sclk, sen_n and sdio; legal values 2–3.

Ports:
- IF_clk  in  1  sole clock; must run at least 8× the sclk frequency.
- rst_n  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock, CPOL=0; sdio is sampled on rising edges.
- sen_n  in  1  frame enable, active low.
- sdio  in  1  serial data in, MSB first.
- sdo  out  1  serial read data.
- sdo_oe  out  1  high while sdo is driven.
- wr_strobe  out  1  one-cycle pulse per accepted write.
- wr_addr  out  5  address of the last accepted write.
- wr_data  out  8  data of the last accepted write.
- rd_addr  in  5  fabric read port address.
- rd_data  out  8  combinational read of regs[rd_addr].
- err_count  out  8  saturating count of bad frames.
- busy  out  1  high while sen_n is low (synchronized).

## Operation

- Frame: 16 bits.
  - bit15: R/W (1 = read).
  - bits14:13: reserved, must be 00.
  - bits12:8: address.
  - bits7:0: data (ignored for reads).
- Synchronizers: SYNC_STAGES flops on each input. Edges are detected from the last two synchronized samples.
- FSM states:
  - IDLE: sen_n high.
  - SHIFT: counting rising edges 1–16.
  - DONE: 16 bits received; further bits ignored until sen_n high.
- Transitions:
  - IDLE→SHIFT: sen_n falls; bit_cnt=0.
  - SHIFT→DONE: 16th rising edge.
  - any state→IDLE: sen_n rises.
- Write frame: on the 16th rising edge with R/W=0 and reserved=00:
  - wr_strobe pulses;
  - wr_addr/wr_data are loaded;
  - regs[addr] is updated.
- Read frame: on the 8th rising edge with R/W=1 and reserved=00:
  - load shift register with regs[addr];
  - sdo_oe=1, sdo=bit7;
  - on each falling edge following rising edges 9–15, shift left and update sdo.
- Read frames never modify regs and never pulse wr_strobe.
- Error: err_count increments, saturating at 0xFF, when any of these occur:
  - sen_n rises with bit_cnt not in {0,16};
  - reserved bits are nonzero (the frame is then ignored).
- sen_n rising: sdo_oe=0 and sdo=0 the next cycle. bit_cnt clears.
- Reset mid-frame: the frame is discarded and all state is reset. After reset, the block waits for sen_n high before accepting a new frame.
- Register file resets to 0x00.

## Timing

- Edge detect latency: SYNC_STAGES+1 IF_clk cycles after the pin edge.
- wr_strobe asserts 1 cycle after the 16th rising edge is detected.
  - wr_addr/wr_data are valid in that same cycle.
  - regs[addr] is visible on rd_data in the following cycle.
- sdo: bit7 is valid 1 cycle after the 8th rising edge is detected. Each shift is 1 cycle after the falling-edge detection.
- Reset values of outputs: sdo=0, sdo_oe=0, wr_strobe=0, wr_addr=0, wr_data=0, err_count=0, busy=0; rd_data=0x00 (all registers clear).
- Simultaneous events:
  - rst_n assertion overrides any write.
  - A write strobe and an error count update in the same cycle are impossible by construction.

## Configuration

- AD9866_SPI_READBACK_EN defined: read frames behave as described above.
- Undefined:
  - read frames are decoded but sdo_oe stays 0 and sdo stays 0;
  - reads are not counted as errors;
  - writes and rd_data are unaffected.

## Test plan

- Write frame 0x0A5C:
  - one wr_strobe with wr_addr=0x0A, wr_data=0x5C;
  - then rd_addr=0x0A gives rd_data=0x5C.
- After the write, read frame 0x8A00:
  - sdo bits 9–16 sampled on rising sclk equal 0x5C;
  - sdo_oe=1 from bit 9 until sen_n high.
  - With AD9866_SPI_READBACK_EN undefined: sdo_oe=0 throughout.
- Abort: sen_n high after 10 bits of 0x0133:
  - no wr_strobe, err_count=1;
  - a following valid frame 0x0133 writes regs[0x01]=0x33.
- Reserved bits set: frame 0x6A11 gives no strobe, err_count increments, regs[0x0A] unchanged.
- rst_n pulse mid-frame (after bit 12): all outputs return to reset values. The next clean frame 0x1FFF writes regs[0x1F]=0xFF.
- 300 abort frames: err_count saturates at 0xFF.
